// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Frames received UART bytes (SYNC, N, N x {HI,LO}, CSUM) into
//                instruction words and writes them into the text RAM. Holds
//                the core in reset while a load is in progress or after a
//                failed load, and releases it after a checksum-verified frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int         ADDR_WIDTH     = 8,
    parameter int         DATA_WIDTH     = 12,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic                  core_reset,
    output logic                  busy,
    output logic                  load_ok,
    output logic                  load_err
);

    // Counter only needs to hold 0..TIMEOUT_CYCLES-1.
    localparam int c_TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);
    // Deepest frame the RAM can hold; 9 bits covers 256 words at ADDR_WIDTH=8.
    localparam logic [8:0] c_DEPTH = 9'(1 << ADDR_WIDTH);
    localparam int c_HI_W = DATA_WIDTH - 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CSUM  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [7:0]          r_checksum;
    logic [8:0]          r_remaining;
    logic [c_HI_W-1:0]   r_hi;
    logic [c_TO_W-1:0]   r_timeout;

    logic                w_is_sync;
    logic                w_in_frame;
    logic                w_to_expired;
    logic [8:0]          w_len_words;
    logic                w_start;
    logic                w_len_ok;
    logic                w_len_bad;
    logic                w_hi;
    logic                w_lo;
    logic                w_csum_ok;
    logic                w_csum_bad;
    logic                w_timeout;

    assign w_is_sync    = rx_valid && (rx_data == SYNC_BYTE);
    assign w_in_frame   = (r_state == ST_LEN) || (r_state == ST_HI) ||
                          (r_state == ST_LO)  || (r_state == ST_CSUM);
    assign w_to_expired = (r_timeout == c_TO_MAX);
    // A length byte of zero encodes a full 256-word frame.
    assign w_len_words  = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
    assign busy         = w_in_frame;

    // Next-state decode and single-cycle action strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_len_ok     = 1'b0;
        w_len_bad    = 1'b0;
        w_hi         = 1'b0;
        w_lo         = 1'b0;
        w_csum_ok    = 1'b0;
        w_csum_bad   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (w_is_sync) begin
                    w_start      = 1'b1;
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (w_len_words > c_DEPTH) begin
                        w_len_bad    = 1'b1;
                        w_state_next = ST_ERROR;
                    end else begin
                        w_len_ok     = 1'b1;
                        w_state_next = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (rx_valid) begin
                    w_hi         = 1'b1;
                    w_state_next = ST_LO;
                end
            end
            ST_LO: begin
                if (rx_valid) begin
                    w_lo         = 1'b1;
                    w_state_next = (r_remaining == 9'd1) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == r_checksum) begin
                        w_csum_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_csum_bad   = 1'b1;
                        w_state_next = ST_ERROR;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        // A byte arriving on the expiry cycle wins over the timeout.
        if (w_in_frame && !rx_valid && w_to_expired) begin
            w_timeout    = 1'b1;
            w_state_next = ST_ERROR;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Inter-byte idle counter, only running inside a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= '0;
        end else if (rx_valid || !w_in_frame || w_timeout) begin
            r_timeout <= '0;
        end else begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    // Running checksum, remaining word count and buffered high byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum  <= 8'h00;
            r_remaining <= 9'd0;
            r_hi        <= '0;
        end else begin
            if (w_start) begin
                r_checksum <= 8'h00;
            end else if (w_len_ok || w_len_bad || w_hi || w_lo) begin
                r_checksum <= r_checksum ^ rx_data;
            end
            if (w_len_ok) begin
                r_remaining <= w_len_words;
            end else if (w_lo) begin
                r_remaining <= r_remaining - 9'd1;
            end
            if (w_hi) begin
                r_hi <= rx_data[c_HI_W-1:0];
            end
        end
    end

    // Text RAM write port: one-cycle strobe after each LO byte, address
    // advancing at the end of the strobe cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            program_write <= 1'b0;
            program_cmd   <= '0;
            uart_address  <= '0;
        end else begin
            program_write <= w_lo;
            if (w_lo) begin
                program_cmd <= {r_hi, rx_data};
            end
            if (w_start) begin
                uart_address <= '0;
            end else if (program_write) begin
                uart_address <= uart_address + 1'b1;
            end
        end
    end

    // Load status and core hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset <= 1'b0;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (w_start) begin
                core_reset <= 1'b1;
                load_ok    <= 1'b0;
                load_err   <= 1'b0;
            end else if (w_csum_ok) begin
                core_reset <= 1'b0;
                load_ok    <= 1'b1;
            end else if (w_csum_bad || w_len_bad || w_timeout) begin
                load_err   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the MC14500B system. It takes received UART bytes, frames them into instruction words, and writes them into the text RAM through the `program_write` / `program_cmd` / `uart_address` write port. While a load is in progress it holds the core (counter, ICU, IO ring) in reset, and releases it only after a checksum-verified frame.

## Interface
- `ADDR_WIDTH`, default 8: text RAM address width; legal range 1..8.
- `DATA_WIDTH`, default 12: instruction word width (opcode + address); legal range 9..16.
- `TIMEOUT_CYCLES`, default 100000: maximum idle clocks allowed between bytes inside a frame.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: single-cycle strobe meaning `rx_data` holds a new byte.
- `rx_data` in 8: received byte.
- `program_write` out 1: one-cycle write strobe to the text RAM.
- `program_cmd` out DATA_WIDTH: word to write.
- `uart_address` out ADDR_WIDTH: write address.
- `core_reset` out 1: high while loading or after a failed load; ORed into the core reset by the top level.
- `busy` out 1: high in states LEN, HI, LO and CSUM.
- `load_ok` out 1: last frame loaded and verified.
- `load_err` out 1: last frame failed (bad length, bad checksum or timeout).

## Operation
- Reset values: `program_write`=0, `program_cmd`=0, `uart_address`=0, `core_reset`=0, `busy`=0, `load_ok`=0, `load_err`=0. State is IDLE, the checksum is 0, and the counters are 0. The core runs the preloaded RAM image.
- Frame format, in byte order: SYNC, N, then N words of {HI, LO}, then CSUM.
  - N = 0 means 256 words.
  - The word is {HI[DATA_WIDTH-9:0], LO}; unused HI bits are ignored.
  - CSUM must equal the XOR of N and every HI and LO byte. SYNC is not included.
- FSM states: IDLE, LEN, HI, LO, CSUM, ERROR.
- IDLE: non-SYNC bytes are ignored. A SYNC byte does the following, then moves to LEN:
  - sets `core_reset`=1;
  - clears `load_ok`, `load_err` and the checksum;
  - sets the write address to 0.
- LEN: latches N as the remaining-word count and XORs it into the checksum.
  - If N (with 0 meaning 256) is greater than 2^ADDR_WIDTH, go to ERROR.
  - Otherwise go to HI.
- HI: stores the byte, XORs it into the checksum, then goes to LO.
- LO: XORs the byte into the checksum and registers the write (see Timing). Then it decrements the remaining count:
  - go to CSUM if the count reaches 0;
  - otherwise go to HI.
- CSUM: compares the received byte with the checksum.
  - Match: `core_reset`=0, `load_ok`=1, go to IDLE.
  - Mismatch: `load_err`=1, go to ERROR.
- ERROR: `core_reset` stays 1 and `load_err` stays 1. Non-SYNC bytes are ignored. A SYNC byte restarts the frame exactly as in IDLE.
- Timeout: in LEN, HI, LO and CSUM, a counter clears on every `rx_valid` and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte, `load_err`=1 and the FSM goes to ERROR.
  - If `rx_valid` arrives on the same cycle as the timeout, the byte wins and no timeout occurs.
- Words written before a failure stay in RAM. No rollback is done; the core stays held until a good frame arrives.
- A SYNC-valued byte inside a frame is treated as data, never as a restart.

## Timing
- `rx_valid` accepted at edge t gives registered outputs from t+1.
- SYNC accepted at edge t: `core_reset`=1 and `busy`=1 from t+1.
- LO accepted at edge t:
  - `program_write`=1 for exactly cycle t+1, with `program_cmd` and `uart_address` valid in that same cycle;
  - `uart_address` increments at edge t+1.
  - The address wraps 2^ADDR_WIDTH-1 → 0, which is only reachable after the final word of a full-depth frame.
- CSUM accepted at edge t: `core_reset`=0, `busy`=0 and `load_ok`=1 from t+1 on a match. On a mismatch, `load_err`=1 from t+1.
- Minimum byte spacing is 1 cycle; back-to-back `rx_valid` must be accepted without loss.
- Asynchronous `reset` mid-frame drives all outputs to their reset values immediately. This includes `core_reset`=0, so the core restarts on the partially written RAM.
- `program_cmd` holds its last value between writes.

## Test plan
- SYNC, 02, 01, 3F, 0A, 12, CSUM=02^01^3F^0A^12=24 -> writes 0x13F at address 0 and 0xA12 at address 1, each a 1-cycle `program_write`; then `core_reset` falls and `load_ok`=1.
- Same frame with CSUM=25 -> both writes occur, then `load_err`=1 and `core_reset` stays 1. A following good frame clears `load_err` and sets `load_ok`.
- Bytes 00, 13, 7F before SYNC -> ignored: no writes, `core_reset`=0. Then a valid 1-word frame loads normally.
- SYNC, 01, 01, then silence for TIMEOUT_CYCLES -> `load_err`=1, ERROR state, no write issued. Sending a byte on the timeout cycle prevents the error.
- ADDR_WIDTH=4, N=0x20 -> ERROR right after LEN with no writes. With N=0x10, 16 writes to addresses 0..15, and `uart_address` wraps to 0 after the last write.
- `reset` pulse after the 3rd word of a 5-word frame, with `rx_valid` back-to-back throughout -> outputs go to reset values asynchronously, 3 words remain written, FSM is in IDLE.
